// File: rtl/sap_pkg.sv
// Shared SAP CPU definitions: output-stage digit count, seven-segment glyphs,
// and the conversion FSM state type.
package sap_pkg;

    localparam int OUT_DIGITS = 3;
    localparam int BCD_W      = 4 * OUT_DIGITS;

    // Segment order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } out_state_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] s;
        case (digit)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble: converts an 8-bit binary value to three BCD digits,
// one add-3/shift iteration per clock.
//
//   state | meaning
//   IDLE  | waiting for start; bcd holds the last completed result
//   CONV  | iterating; cnt counts completed shifts (0..7)
module bin2bcd
    import sap_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        bin,
    output logic              busy,
    output logic              done,
    output logic [BCD_W-1:0]  bcd
);

    out_state_t  state;
    logic [19:0] sr;
    logic [19:0] adj;
    logic [19:0] next_sr;
    logic [2:0]  cnt;

    always_comb begin
        adj = sr;
        for (int i = 0; i < OUT_DIGITS; i++) begin
            if (sr[8 + 4*i +: 4] >= 4'd5) begin
                adj[8 + 4*i +: 4] = sr[8 + 4*i +: 4] + 4'd3;
            end
        end
        next_sr = adj << 1;
    end

    assign busy = (state == CONV);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            bcd   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr    <= {12'b0, bin};
                        cnt   <= '0;
                        state <= CONV;
                    end
                end
                CONV: begin
                    // The final shift always retires, so a start arriving on
                    // that same edge chains straight into the next conversion.
                    if (cnt == 3'd7) begin
                        bcd  <= next_sr[19:8];
                        done <= 1'b1;
                    end
                    if (start) begin
                        sr    <= {12'b0, bin};
                        cnt   <= '0;
                        state <= CONV;
                    end else if (cnt == 3'd7) begin
                        sr    <= next_sr;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        sr  <= next_sr;
                        cnt <= cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/out_display.sv
// SAP CPU output stage: bus-loaded output register, BCD conversion, and a
// time-multiplexed three-digit seven-segment driver with leading-zero blanking.
module out_display
    import sap_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [7:0]             bus,
    output logic [7:0]             out,
    output logic [BCD_W-1:0]       bcd,
    output logic                   busy,
    output logic                   valid,
    output logic [OUT_DIGITS-1:0]  an,
    output logic [6:0]             seg
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] scan_cnt;
    logic [3:0]       digit;
    logic             blank;

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else if (load) begin
            out <= bus;
        end
    end

    bin2bcd u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (load),
        .bin   (bus),
        .busy  (busy),
        .done  (valid),
        .bcd   (bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            an       <= 3'b001;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            an       <= {an[1:0], an[2]};
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        digit = bcd[3:0];
        blank = 1'b0;
        case (an)
            3'b010: begin
                digit = bcd[7:4];
                blank = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
            end
            3'b100: begin
                digit = bcd[11:8];
                blank = (bcd[11:8] == 4'd0);
            end
            default: begin
                digit = bcd[3:0];
                blank = 1'b0;
            end
        endcase
        seg = blank ? SEG_BLANK : seg_encode(digit);
    end

endmodule

// File: tb/tb_out_display.sv
// Directed bench for out_display: reset, scan timing, conversions, restart,
// mid-conversion reset and back-to-back loads.
module tb_out_display;

    logic        clk;
    logic        rst;
    logic        load;
    logic [7:0]  bus;
    logic [7:0]  out;
    logic [11:0] bcd;
    logic        busy;
    logic        valid;
    logic [2:0]  an;
    logic [6:0]  seg;

    int checks   = 0;
    int failures = 0;
    int vcount;

    out_display #(.SCAN_DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .bus   (bus),
        .out   (out),
        .bcd   (bcd),
        .busy  (busy),
        .valid (valid),
        .an    (an),
        .seg   (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        bus  = v;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_an(input logic [2:0] target);
        int n = 0;
        while (an !== target && n < 20) begin
            tick();
            n++;
        end
        if (an !== target) check("wait_an_timeout", {29'b0, an}, {29'b0, target});
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, {31'b0, valid}, 32'd1);
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        bus  = 8'h00;
        tick();
        tick();
        check("rst_out",   out,   0);
        check("rst_bcd",   bcd,   0);
        check("rst_busy",  busy,  0);
        check("rst_valid", valid, 0);
        check("rst_an",    an,    3'b001);
        check("rst_seg",   seg,   7'b0111111);
        rst = 1'b0;

        // Scan: an changes after edges 4, 8, 12 following reset release
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 3)  check("scan_e3",  an, 3'b001);
            if (e == 4)  begin check("scan_e4", an, 3'b010); check("seg_tens_blank0", seg, 7'b0); end
            if (e == 7)  check("scan_e7",  an, 3'b010);
            if (e == 8)  begin check("scan_e8", an, 3'b100); check("seg_hund_blank0", seg, 7'b0); end
            if (e == 12) begin check("scan_e12", an, 3'b001); check("seg_ones_0", seg, 7'b0111111); end
        end

        // 255: busy for 8 cycles, one valid pulse at k+8
        do_load(8'd255);
        check("ld255_out",  out,  8'hFF);
        check("ld255_busy", busy, 1);
        vcount = 0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (valid) vcount++;
            check("ld255_busy_mid", busy, 1);
        end
        tick();
        check("ld255_bcd",   bcd,   12'h255);
        check("ld255_valid", valid, 1);
        check("ld255_busy0", busy,  0);
        check("ld255_early_valid", vcount, 0);
        tick();
        check("ld255_valid_pulse", valid, 0);
        wait_an(3'b001); check("d255_ones", seg, 7'b1101101);
        wait_an(3'b010); check("d255_tens", seg, 7'b1101101);
        wait_an(3'b100); check("d255_hund", seg, 7'b1011011);

        // 42: hundreds blank, tens '4', ones '2'
        do_load(8'd42);
        wait_done("ld42_done");
        check("ld42_bcd", bcd, 12'h042);
        wait_an(3'b100); check("d42_hund", seg, 7'b0000000);
        wait_an(3'b001); check("d42_ones", seg, 7'b1011011);
        wait_an(3'b010); check("d42_tens", seg, 7'b1100110);

        // 100 restarted by 7 at k+3
        do_load(8'd100);
        vcount = 0;
        tick(); if (valid) vcount++;
        tick(); if (valid) vcount++;
        do_load(8'd7);
        check("rs_out", out, 8'd7);
        check("rs_bcd_hold", bcd, 12'h042);
        for (int i = 4; i <= 10; i++) begin
            tick();
            if (valid) vcount++;
        end
        check("rs_bcd_hold_k10", bcd, 12'h042);
        check("rs_no_valid", vcount, 0);
        tick();
        check("rs_valid_k11", valid, 1);
        check("rs_bcd_k11",   bcd,   12'h007);
        wait_an(3'b010); check("d7_tens_blank", seg, 7'b0);
        wait_an(3'b001); check("d7_ones", seg, 7'b0000111);

        // Reset at k+5 during conversion of 200
        do_load(8'd200);
        for (int i = 1; i <= 4; i++) tick();
        rst = 1'b1;
        tick();
        check("mr_out",   out,   0);
        check("mr_bcd",   bcd,   0);
        check("mr_busy",  busy,  0);
        check("mr_valid", valid, 0);
        check("mr_an",    an,    3'b001);
        check("mr_seg",   seg,   7'b0111111);
        rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid) vcount++;
        end
        check("mr_no_valid", vcount, 0);
        check("mr_bcd_after", bcd, 0);

        // Back-to-back: 9 at k, 10 at k+8
        do_load(8'd9);
        vcount = 0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (valid) vcount++;
        end
        do_load(8'd10);
        if (valid) vcount++;
        check("bb_bcd_k8", bcd, 12'h009);
        check("bb_valid_k8", valid, 1);
        check("bb_out_k8", out, 8'd10);
        check("bb_busy_k8", busy, 1);
        for (int i = 9; i <= 16; i++) begin
            tick();
            if (valid) vcount++;
        end
        check("bb_bcd_k16", bcd, 12'h010);
        check("bb_valid_k16", valid, 1);
        check("bb_valid_count", vcount, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
